// File: rtl/bin_pkg.sv
// -----------------------------------------------------------------------------
// bin_pkg
// Shared definitions for the adaptive binarizer:
//   - luma_t            : 8-bit luma sample type
//   - MODE_ADAPTIVE_BIT : mode_in bit that selects the adaptive threshold
//   - MODE_INVERT_BIT   : mode_in bit that inverts the output bit
//   - rgb565_to_luma()  : RGB565 -> 8-bit luma, Y = (2R + 5G + B) >> 3
// -----------------------------------------------------------------------------
package bin_pkg;

    localparam int MODE_ADAPTIVE_BIT = 0;
    localparam int MODE_INVERT_BIT   = 1;

    typedef logic [7:0] luma_t;

    // The 5/6-bit channels are widened to 8 bits by replicating their MSBs
    // into the new LSBs, so full-scale inputs map to exactly 255. The
    // weighted sum peaks at 8 * 255 = 2040 and fits in 11 bits.
    function automatic luma_t rgb565_to_luma(input logic [15:0] pix);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [10:0] acc;
        r8  = {pix[15:11], pix[15:13]};
        g8  = {pix[10:5], pix[10:9]};
        b8  = {pix[4:0], pix[4:2]};
        acc = {2'b00, r8, 1'b0}     // 2R
            + {1'b0, g8, 2'b00}     // 4G
            + {3'b000, g8}          // +G
            + {3'b000, b8};         // B
        return acc[10:3];
    endfunction

endpackage

// File: rtl/row_window_mean.sv
// -----------------------------------------------------------------------------
// row_window_mean
// Sliding window over the last N = 2^WIN_LOG2 luma samples of a row.
// Keeps a circular buffer, a running sum and a fill counter.
//
// Ports:
//   clk_in    in   pixel clock
//   rst_in    in   asynchronous active-low reset (window empty)
//   push_in   in   append y_in to the window this cycle
//   clear_in  in   empty the window; applied before a same-cycle push
//   y_in      in   luma sample to append
//   mean_out  out  running sum >> WIN_LOG2 (meaningful when full_out=1)
//   full_out  out  window holds N samples
//
// mean_out/full_out reflect the window *before* this cycle's push/clear,
// so a caller deciding on the current sample sees only previous samples.
// -----------------------------------------------------------------------------
module row_window_mean
    import bin_pkg::*;
#(
    parameter int WIN_LOG2 = 4
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  push_in,
    input  logic  clear_in,
    input  luma_t y_in,
    output luma_t mean_out,
    output logic  full_out
);

    localparam int N      = 1 << WIN_LOG2;
    localparam int SUM_W  = 8 + WIN_LOG2;
    localparam int FILL_W = WIN_LOG2 + 1;
    localparam int PTR_W  = WIN_LOG2;

    luma_t              buf_q [N];
    logic [SUM_W-1:0]   sum_q,  sum_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PTR_W-1:0]   ptr_q,  ptr_d;

    // Write slot for this cycle's push; a clear rewinds to slot 0 first.
    logic [PTR_W-1:0]   wr_ptr;
    luma_t              oldest;
    logic               full_before_push;

    always_comb begin
        sum_d            = sum_q;
        fill_d           = fill_q;
        ptr_d            = ptr_q;
        wr_ptr           = ptr_q;
        oldest           = '0;
        full_before_push = (fill_q == FILL_W'(N));

        if (clear_in) begin
            sum_d            = '0;
            fill_d           = '0;
            ptr_d            = '0;
            wr_ptr           = '0;
            full_before_push = 1'b0;
        end

        if (push_in) begin
            // Only a full window has a real oldest sample to retire; before
            // that the slot being written holds stale data.
            if (full_before_push) begin
                oldest = buf_q[wr_ptr];
            end
            sum_d = sum_d + SUM_W'(y_in) - SUM_W'(oldest);
            ptr_d = wr_ptr + PTR_W'(1);
            if (!full_before_push) begin
                fill_d = fill_d + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sum_q  <= '0;
            fill_q <= '0;
            ptr_q  <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            sum_q  <= sum_d;
            fill_q <= fill_d;
            ptr_q  <= ptr_d;
            if (push_in) begin
                buf_q[wr_ptr] <= y_in;
            end
        end
    end

    assign mean_out = sum_q[SUM_W-1:WIN_LOG2];
    assign full_out = (fill_q == FILL_W'(N));

endmodule

// File: rtl/adaptive_binarizer.sv
// -----------------------------------------------------------------------------
// adaptive_binarizer
// RGB565 pixel stream -> 1-bit framebuffer writes. Each accepted pixel is
// converted to luma and thresholded either against a global threshold or
// against the mean of the previous 2^WIN_LOG2 pixels of the same row plus
// an offset. Output bit, framebuffer address and write enable leave
// together, exactly two cycles after valid_in.
//
// Stream protocol: valid-only, no backpressure. valid_in qualifies
// pixel_in/hcount_in/vcount_in/mode_in/thresh_in/offset_in for one cycle;
// we_out qualifies bin_out/addr_out for one cycle. One pixel per cycle.
//
// Ports:
//   clk_in           in   pixel clock
//   rst_in           in   asynchronous active-low reset
//   pixel_in[15:0]   in   RGB565 {R5,G6,B5}
//   hcount_in[10:0]  in   pixel column
//   vcount_in[9:0]   in   pixel row
//   valid_in         in   pixel valid
//   mode_in[1:0]     in   bit0 adaptive, bit1 invert
//   thresh_in[7:0]   in   global threshold (also adaptive row-start fallback)
//   offset_in[7:0]   in   adaptive offset C
//   bin_out          out  binarised pixel, 1 = white
//   addr_out         out  hcount + WIDTH*vcount of bin_out
//   we_out           out  framebuffer write enable
//   white_count_out  out  (BIN_STATS_EN) white pixels in last completed frame
//   stats_valid_out  out  (BIN_STATS_EN) one-cycle pulse when it updates
//
// Optional feature macro: BIN_STATS_EN adds the per-frame white counter.
// -----------------------------------------------------------------------------
module adaptive_binarizer
    import bin_pkg::*;
#(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int WIN_LOG2 = 4,
    parameter int ADDR_W   = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [15:0]       pixel_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              valid_in,
    input  logic [1:0]        mode_in,
    input  logic [7:0]        thresh_in,
    input  logic [7:0]        offset_in,
    output logic              bin_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              we_out
`ifdef BIN_STATS_EN
    ,
    output logic [ADDR_W-1:0] white_count_out,
    output logic              stats_valid_out
`endif
);

    // ------------------------------------------------------------------
    // Stage 1: luma, address, range check; controls captured with pixel
    // ------------------------------------------------------------------
    logic              s1_valid_q;
    logic              s1_in_range_q, s1_in_range_d;
    logic              s1_row_start_q;
    luma_t             s1_y_q,        s1_y_d;
    logic [ADDR_W-1:0] s1_addr_q,     s1_addr_d;
    logic [1:0]        s1_mode_q;
    logic [7:0]        s1_thresh_q;
    logic [7:0]        s1_offset_q;

    always_comb begin
        s1_y_d        = rgb565_to_luma(pixel_in);
        s1_addr_d     = ADDR_W'(hcount_in) + ADDR_W'(WIDTH) * ADDR_W'(vcount_in);
        s1_in_range_d = (int'(hcount_in) < WIDTH) && (int'(vcount_in) < HEIGHT);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid_q     <= 1'b0;
            s1_in_range_q  <= 1'b0;
            s1_row_start_q <= 1'b0;
            s1_y_q         <= '0;
            s1_addr_q      <= '0;
            s1_mode_q      <= '0;
            s1_thresh_q    <= '0;
            s1_offset_q    <= '0;
        end else begin
            s1_valid_q <= valid_in;
            if (valid_in) begin
                s1_in_range_q  <= s1_in_range_d;
                s1_row_start_q <= (hcount_in == 11'd0);
                s1_y_q         <= s1_y_d;
                s1_addr_q      <= s1_addr_d;
                s1_mode_q      <= mode_in;
                s1_thresh_q    <= thresh_in;
                s1_offset_q    <= offset_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Row window: advanced only by accepted in-range pixels
    // ------------------------------------------------------------------
    logic  win_push;
    logic  win_clear;
    luma_t win_mean;
    logic  win_full;

    assign win_push  = s1_valid_q & s1_in_range_q;
    assign win_clear = win_push & s1_row_start_q;

    row_window_mean #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_window (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push_in  (win_push),
        .clear_in (win_clear),
        .y_in     (s1_y_q),
        .mean_out (win_mean),
        .full_out (win_full)
    );

    // ------------------------------------------------------------------
    // Stage 2: decision
    // ------------------------------------------------------------------
    logic              use_adaptive;
    logic              global_bit;
    logic              adaptive_bit;
    logic              bin_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic              bin_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        // A row-start pixel clears the window before its own decision, so
        // it can never be judged against the previous row.
        use_adaptive = s1_mode_q[MODE_ADAPTIVE_BIT] & win_full & ~s1_row_start_q;
        global_bit   = (s1_y_q >= s1_thresh_q);
        // 9-bit compare: Y + C can exceed 255 without wrapping.
        adaptive_bit = (({1'b0, s1_y_q} + {1'b0, s1_offset_q}) >= {1'b0, win_mean});
        bin_d        = (use_adaptive ? adaptive_bit : global_bit)
                       ^ s1_mode_q[MODE_INVERT_BIT];
        we_d         = win_push;
        addr_d       = s1_addr_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bin_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            bin_q  <= bin_d;
            we_q   <= we_d;
            addr_q <= addr_d;
        end
    end

    assign bin_out  = bin_q;
    assign we_out   = we_q;
    assign addr_out = addr_q;

`ifdef BIN_STATS_EN
    // ------------------------------------------------------------------
    // Per-frame white pixel counter. Driven from the stage-2 next-state
    // values so the latch/pulse lines up with the final pixel's we_out.
    // ------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    logic [ADDR_W-1:0] white_cnt_q,  white_cnt_d;
    logic [ADDR_W-1:0] white_hold_q, white_hold_d;
    logic              stats_vld_q,  stats_vld_d;
    logic [ADDR_W-1:0] white_cnt_inc;

    always_comb begin
        white_cnt_inc = white_cnt_q + ADDR_W'(we_d & bin_d);
        white_cnt_d   = white_cnt_inc;
        white_hold_d  = white_hold_q;
        stats_vld_d   = 1'b0;
        if (we_d && (addr_d == LAST_ADDR)) begin
            white_hold_d = white_cnt_inc;
            white_cnt_d  = '0;
            stats_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            white_cnt_q  <= '0;
            white_hold_q <= '0;
            stats_vld_q  <= 1'b0;
        end else begin
            white_cnt_q  <= white_cnt_d;
            white_hold_q <= white_hold_d;
            stats_vld_q  <= stats_vld_d;
        end
    end

    assign white_count_out = white_hold_q;
    assign stats_valid_out = stats_vld_q;
`endif

endmodule

// File: tb/tb_adaptive_binarizer.sv
module tb_adaptive_binarizer;

  localparam int WIDTH    = 640;
  localparam int HEIGHT   = 480;
  localparam int WIN_LOG2 = 4;
  localparam int N        = 1 << WIN_LOG2;
  localparam int AW       = $clog2(WIDTH * HEIGHT);

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic [15:0] pixel  = '0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        valid  = 1'b0;
  logic [1:0]  mode   = '0;
  logic [7:0]  thresh = '0;
  logic [7:0]  offset = '0;

  // DUT outputs
  logic          bin_out;
  logic [AW-1:0] addr_out;
  logic          we_out;
`ifdef BIN_STATS_EN
  logic [AW-1:0] white_count;
  logic          stats_valid;
`endif

  int checks = 0;
  int errors = 0;

  // scoreboard: {bin, addr} per expected framebuffer write
  logic [AW:0] exp_q[$];
  // reference row history for randomised stimulus
  int hist[$];

  adaptive_binarizer #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .WIN_LOG2 (WIN_LOG2),
    .ADDR_W   (AW)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .pixel_in        (pixel),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .valid_in        (valid),
    .mode_in         (mode),
    .thresh_in       (thresh),
    .offset_in       (offset),
    .bin_out         (bin_out),
    .addr_out        (addr_out),
    .we_out          (we_out)
`ifdef BIN_STATS_EN
    ,
    .white_count_out (white_count),
    .stats_valid_out (stats_valid)
`endif
  );

  // scoreboard consumer: every write must match the oldest expectation
  always @(negedge clk) begin
    if (we_out === 1'b1) begin
      logic [AW:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we: got bin=%0b addr=%0d, required no write", bin_out, addr_out);
      end else begin
        e = exp_q.pop_front();
        if ({bin_out, addr_out} !== e) begin
          errors++;
          $display("FAIL write: got bin=%0b addr=%0d, required bin=%0b addr=%0d",
                   bin_out, addr_out, e[AW], e[AW-1:0]);
        end
      end
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // independent luma reference written arithmetically
  function automatic int model_luma(input logic [15:0] p);
    int r, g, b, r8, g8, b8;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    return (2 * r8 + 5 * g8 + b8) / 8;
  endfunction

  // driver tasks
  task automatic send_px(input logic [15:0] p, input int h, input int v, input logic eb);
    @(negedge clk);
    pixel  = p;
    hcount = h[10:0];
    vcount = v[9:0];
    valid  = 1'b1;
    if (h < WIDTH && v < HEIGHT) exp_q.push_back({eb, AW'(h + WIDTH * v)});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      valid = 1'b0;
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  // tests
  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    checks++;
    if (bin_out !== 1'b0) begin errors++; $display("FAIL reset_bin: got %0b required 0", bin_out); end
    checks++;
    if (addr_out !== '0) begin errors++; $display("FAIL reset_addr: got %0d required 0", addr_out); end
    checks++;
    if (we_out !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b required 0", we_out); end
`ifdef BIN_STATS_EN
    checks++;
    if (white_count !== '0) begin errors++; $display("FAIL reset_white: got %0d required 0", white_count); end
    checks++;
    if (stats_valid !== 1'b0) begin errors++; $display("FAIL reset_stats_valid: got %0b required 0", stats_valid); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_global;
    mode = 2'b00; thresh = 8'd128; offset = 8'd0;
    send_px(16'hFFFF, 0, 0, 1'b1);
    send_px(16'h0000, 1, 0, 1'b0);
    @(negedge clk); valid = 1'b0;
    // first pixel's output two cycles after it was driven
    checks++;
    if ({we_out, bin_out, addr_out} !== {1'b1, 1'b1, AW'(0)}) begin
      errors++;
      $display("FAIL global_latency0: got we=%0b bin=%0b addr=%0d required we=1 bin=1 addr=0", we_out, bin_out, addr_out);
    end
    @(negedge clk);
    checks++;
    if ({we_out, bin_out, addr_out} !== {1'b1, 1'b0, AW'(1)}) begin
      errors++;
      $display("FAIL global_latency1: got we=%0b bin=%0b addr=%0d required we=1 bin=0 addr=1", we_out, bin_out, addr_out);
    end
    @(negedge clk);
    checks++;
    if (we_out !== 1'b0) begin errors++; $display("FAIL global_we_pulse: got %0b required 0", we_out); end
    drain("global");
  endtask

  task automatic test_adaptive;
    mode = 2'b01; thresh = 8'd50; offset = 8'd10;
    for (int h = 0; h < 16; h++) send_px(16'h632C, h, 2, 1'b1);  // Y=100, global fallback
    send_px(16'h0000, 16, 2, 1'b0);  // 0+10 < mean 100
    send_px(16'hFFFF, 17, 2, 1'b1);  // 255+10 >= mean 93
    drain("adaptive");
  endtask

  task automatic test_row_restart;
    mode = 2'b01; thresh = 8'd50; offset = 8'd10;
    // black row: global 0 for the fill-up pixels, then 0+10 >= mean 0
    for (int h = 0; h < WIDTH; h++) send_px(16'h0000, h, 0, (h >= N));
    // Y=40 at row start: global fallback 40 < 50 (stale mean 0 would give 1)
    send_px(16'h2945, 0, 1, 1'b0);
    drain("row_restart");
  endtask

  task automatic test_range_invert;
    mode = 2'b11; thresh = 8'd128; offset = 8'd10;
    send_px(16'hFFFF, WIDTH, 0, 1'b0);   // out of range: no write expected
    send_px(16'hFFFF, 5, HEIGHT, 1'b0);  // out of range: no write expected
    @(negedge clk); valid = 1'b0;
    checks++;
    if (we_out !== 1'b0) begin errors++; $display("FAIL range_h_we: got %0b required 0", we_out); end
    @(negedge clk);
    checks++;
    if (we_out !== 1'b0) begin errors++; $display("FAIL range_v_we: got %0b required 0", we_out); end
    send_px(16'hFFFF, WIDTH - 1, HEIGHT - 1, 1'b0);  // 255>=128 inverted
    drain("range_invert");
  endtask

  task automatic test_reset_mid_row;
    mode = 2'b01; thresh = 8'd50; offset = 8'd10;
    for (int h = 0; h < 12; h++) send_px(16'hFFFF, h, 5, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({we_out, bin_out, addr_out} !== {1'b0, 1'b0, AW'(0)}) begin
      errors++;
      $display("FAIL midreset_outputs: got we=%0b bin=%0b addr=%0d required all 0", we_out, bin_out, addr_out);
    end
    idle(2);
    checks++;
    if (we_out !== 1'b0) begin errors++; $display("FAIL midreset_we_hold: got %0b required 0", we_out); end
    rst_n = 1'b1;
    idle(3);
    // window restarts empty: 16 global decisions (100>=50), then 0+10 < 100
    for (int i = 0; i < N; i++) send_px(16'h632C, 12 + i, 5, 1'b1);
    send_px(16'h0000, 12 + N, 5, 1'b0);
    drain("reset_mid_row");
  endtask

  task automatic test_back_to_back;
    int h, hh, v, y, s, mean;
    logic b;
    logic [15:0] p;
    logic [1:0] m;
    logic [7:0] t, o;
    hist.delete();
    h = 0;
    v = 10;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 3)));
      if (i == 200) begin h = 0; v = 11; end
      p  = 16'($urandom_range(0, 65535));
      m  = 2'($urandom_range(0, 3));
      t  = 8'($urandom_range(0, 255));
      o  = 8'($urandom_range(0, 40));
      hh = ($urandom_range(0, 19) == 0) ? WIDTH + int'($urandom_range(0, 50)) : h;
      @(negedge clk);
      pixel = p; hcount = hh[10:0]; vcount = v[9:0];
      mode = m; thresh = t; offset = o; valid = 1'b1;
      if (hh < WIDTH) begin
        y = model_luma(p);
        if (hh == 0) hist.delete();
        if (m[0] && hist.size() == N) begin
          s = 0;
          foreach (hist[k]) s += hist[k];
          mean = s / N;
          b = (y + int'(o) >= mean);
        end else begin
          b = (y >= int'(t));
        end
        b = b ^ m[1];
        hist.push_back(y);
        if (hist.size() > N) void'(hist.pop_front());
        exp_q.push_back({b, AW'(hh + WIDTH * v)});
        h++;
      end
    end
    drain("back_to_back");
  endtask

`ifdef BIN_STATS_EN
  task automatic test_stats;
    @(negedge clk); rst_n = 1'b0; valid = 1'b0; exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    mode = 2'b00; thresh = 8'd128; offset = 8'd0;
    for (int i = 0; i < 1050; i++)
      send_px((i < 1000) ? 16'hFFFF : 16'h0000, i % WIDTH, i / WIDTH, (i < 1000));
    send_px(16'h0000, WIDTH - 1, HEIGHT - 1, 1'b0);
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({we_out, stats_valid} !== 2'b11) begin
      errors++;
      $display("FAIL stats_pulse: got we=%0b stats_valid=%0b required 1 1", we_out, stats_valid);
    end
    checks++;
    if (white_count !== AW'(1000)) begin
      errors++;
      $display("FAIL stats_count: got %0d required 1000", white_count);
    end
    @(negedge clk);
    checks++;
    if (stats_valid !== 1'b0) begin errors++; $display("FAIL stats_single: got %0b required 0", stats_valid); end
    drain("stats");
  endtask
`endif

  initial begin
    test_reset();
    test_global();
    test_adaptive();
    test_row_restart();
    test_range_invert();
    test_reset_mid_row();
    test_back_to_back();
`ifdef BIN_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
